// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-boundary definitions: register-index/control widths, NOP control
// and the default-width stage payload used at the ID/EX, EX/MEM and MEM/WB boundaries.
package pipe_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned WB_CTRL_W  = 2;
    localparam int unsigned MEM_CTRL_W = 2;
    localparam int unsigned CTRL_W_DEF = WB_CTRL_W + MEM_CTRL_W;
    localparam int unsigned DATA_W_DEF = 64;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

    typedef struct packed {
        logic                  valid;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
        logic [REG_IDX_W-1:0]  rd;
    } stage_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a pipeline stage and its boundary register.
// PIPE_STAGE_REG_STATS_EN adds the stall/flush statistics counters.
interface pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DEPTH  = 1
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_STAGE_REG_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    modport master (
        output stall, flush, in_valid, in_ctrl, in_data, in_rd,
        input  out_valid, out_ctrl, out_data, out_rd, occupancy
`ifdef PIPE_STAGE_REG_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  stall, flush, in_valid, in_ctrl, in_data, in_rd,
        output out_valid, out_ctrl, out_data, out_rd, occupancy
`ifdef PIPE_STAGE_REG_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline stage register. Priority: clear (bubble, data kept) > hold > load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter  int unsigned CTRL_W = 4,
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned RD_W   = 5,
    localparam int unsigned SLOT_W = 1 + CTRL_W + DATA_W + RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hold,
    input  logic [SLOT_W-1:0] d,
    output logic [SLOT_W-1:0] q
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } slot_t;

    slot_t d_s;
    slot_t q_r;

    assign d_s = slot_t'(d);
    assign q   = SLOT_W'(q_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else if (clear) begin
            q_r.valid <= 1'b0;
            q_r.ctrl  <= CTRL_W'(NOP_CTRL);
            q_r.rd    <= '0;
        end else if (!hold) begin
            q_r <= d_s;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (DEPTH chained slots) with stall, flush,
// NOP bubbles and occupancy. PIPE_STAGE_REG_STATS_EN adds saturating stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = WB_CTRL_W + MEM_CTRL_W,
    parameter int unsigned RD_W   = REG_IDX_W,
    parameter int unsigned DEPTH  = 1
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    pipe_stage_reg_if.slave bus
);

    localparam int unsigned SLOT_W = 1 + CTRL_W + DATA_W + RD_W;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } slot_t;

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
        $error("pipe_stage_reg: DEPTH=%0d outside legal range 1..4", DEPTH);
    end

    slot_t             in0;
    slot_t             last;
    logic [SLOT_W-1:0] chain [DEPTH+1];
    logic [OCC_W-1:0]  occ_r;

    // Invalid input enters as a NOP bubble: control and rd forced to zero, data passes.
    always_comb begin
        in0       = '0;
        in0.valid = bus.in_valid;
        in0.data  = bus.in_data;
        if (bus.in_valid) begin
            in0.ctrl = bus.in_ctrl;
            in0.rd   = bus.in_rd;
        end
    end

    assign chain[0] = SLOT_W'(in0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W),
            .RD_W   (RD_W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .clear (bus.flush),
            .hold  (bus.stall),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    assign last          = slot_t'(chain[DEPTH]);
    assign bus.out_valid = last.valid;
    assign bus.out_ctrl  = last.ctrl;
    assign bus.out_data  = last.data;
    assign bus.out_rd    = last.rd;
    assign bus.occupancy = occ_r;

    // Occupancy tracks the slots in the same edge: in_valid enters, last-stage valid leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_r <= '0;
        end else if (bus.flush) begin
            occ_r <= '0;
        end else if (!bus.stall) begin
            occ_r <= occ_r + OCC_W'(bus.in_valid) - OCC_W'(last.valid);
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (bus.flush && (flush_cnt_r != '1)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
            if (bus.stall && !bus.flush && (stall_cnt_r != '1)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
    assign bus.flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg (DEPTH=2) against a queue-style
// reference model of the boundary register; PIPE_STAGE_REG_STATS_EN also checks counters.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_W   = 5;
`ifdef PIPE_STAGE_REG_STATS_EN
    localparam int unsigned CNT_W  = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)
`ifdef PIPE_STAGE_REG_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) bus ();

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .DEPTH(DEPTH)
`ifdef PIPE_STAGE_REG_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: pipe_m[0] is the entry slot, pipe_m[DEPTH-1] feeds the outputs.
    typedef struct {
        bit        v;
        bit [3:0]  c;
        bit [63:0] d;
        bit [4:0]  r;
    } ent_t;

    ent_t pipe_m [DEPTH];
    int   stall_m;
    int   flush_m;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) pipe_m[i] = '{v: 0, c: 0, d: 0, r: 0};
        stall_m = 0;
        flush_m = 0;
    endtask

    task automatic model_edge();
        ent_t nw;
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_m[i].v = 0;
                pipe_m[i].c = 0;
                pipe_m[i].r = 0;
            end
            flush_m = flush_m + 1;
        end else if (bus.stall) begin
            stall_m = stall_m + 1;
        end else begin
            nw.v = bus.in_valid;
            nw.c = bus.in_valid ? bus.in_ctrl : 4'd0;
            nw.d = bus.in_data;
            nw.r = bus.in_valid ? bus.in_rd : 5'd0;
            for (int i = DEPTH - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
            pipe_m[0] = nw;
        end
    endtask

    task automatic compare_all(input string tag);
        int occ;
        occ = 0;
        for (int i = 0; i < DEPTH; i++) occ += int'(pipe_m[i].v);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(pipe_m[DEPTH-1].v));
        chk({tag, "_ctrl"},  64'(bus.out_ctrl),  64'(pipe_m[DEPTH-1].c));
        chk({tag, "_data"},  bus.out_data,       pipe_m[DEPTH-1].d);
        chk({tag, "_rd"},    64'(bus.out_rd),    64'(pipe_m[DEPTH-1].r));
        chk({tag, "_occ"},   64'(bus.occupancy), 64'(occ));
`ifdef PIPE_STAGE_REG_STATS_EN
        chk({tag, "_stallcnt"}, 64'(bus.stall_cnt), 64'((stall_m > CNT_MAX) ? CNT_MAX : stall_m));
        chk({tag, "_flushcnt"}, 64'(bus.flush_cnt), 64'((flush_m > CNT_MAX) ? CNT_MAX : flush_m));
`endif
    endtask

    task automatic drive(input bit v, input bit [3:0] c, input bit [63:0] d,
                         input bit [4:0] r, input bit s, input bit f);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = d;
        bus.in_rd    = r;
        bus.stall    = s;
        bus.flush    = f;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_ctrl"},  64'(bus.out_ctrl),  64'd0);
        chk({tag, "_rd"},    64'(bus.out_rd),    64'd0);
        chk({tag, "_occ"},   64'(bus.occupancy), 64'd0);
    endtask

    bit [63:0] held_data;

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        #2;
        check_reset_outputs("rst_init");
        #10 rst = 1'b1;

        // Latency: first instruction appears DEPTH edges later, occupancy 1,2,1.
        drive(1, 4'b1010, 64'h1234, 5'd9, 0, 0);
        step("lat_e1");
        chk("lat_occ1", 64'(bus.occupancy), 64'd1);
        drive(1, 4'b0101, 64'h5678, 5'd2, 0, 0);
        step("lat_e2");
        chk("lat_occ2", 64'(bus.occupancy), 64'd2);
        chk("lat_out_rd", 64'(bus.out_rd), 64'd9);
        chk("lat_out_ctrl", 64'(bus.out_ctrl), 64'hA);
        chk("lat_out_data", bus.out_data, 64'h1234);
        drive(0, 0, 0, 0, 0, 0);
        step("lat_e3");
        chk("lat_occ3", 64'(bus.occupancy), 64'd1);
        step("lat_e4");

        // Stall: rd=7 frozen inside, rd=3 offered during the stall is never captured.
        drive(1, 4'h3, 64'h77, 5'd7, 0, 0);
        step("stl_load");
        drive(1, 4'h6, 64'h33, 5'd3, 1, 0);
        repeat (3) step("stl_hold");
        chk("stl_frozen_valid", 64'(bus.out_valid), 64'd0);
        drive(0, 0, 0, 0, 0, 0);
        step("stl_rel1");
        chk("stl_rd7", 64'(bus.out_rd), 64'd7);
        step("stl_rel2");
        chk("stl_no_rd3", 64'(bus.out_valid), 64'd0);

        // Flush overrides stall on a full pipe; data is retained.
        drive(1, 4'h9, 64'hAAAA, 5'd11, 0, 0);
        step("fl_fill1");
        drive(1, 4'hC, 64'hBBBB, 5'd12, 0, 0);
        step("fl_fill2");
        chk("fl_full", 64'(bus.occupancy), 64'd2);
        held_data = pipe_m[DEPTH-1].d;
        drive(1, 4'hF, 64'hCCCC, 5'd13, 1, 1);
        step("fl_edge");
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_occ", 64'(bus.occupancy), 64'd0);
        chk("fl_data_kept", bus.out_data, 64'hAAAA);
        chk("fl_data_model", bus.out_data, held_data);

        // Bubble: invalid input with non-zero ctrl/rd becomes a NOP.
        drive(0, 4'b1111, 64'hBEEF, 5'd31, 0, 0);
        step("bub1");
        step("bub2");
        chk("bub_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("bub_rd", 64'(bus.out_rd), 64'd0);
        chk("bub_occ", 64'(bus.occupancy), 64'd0);

        // Asynchronous reset mid-stream, asserted between edges.
        drive(1, 4'h5, 64'hF00D, 5'd17, 0, 0);
        step("mrst_fill1");
        step("mrst_fill2");
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mrst");
        model_clear();
        #3 rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step("mrst_after");

`ifdef PIPE_STAGE_REG_STATS_EN
        // 5 stalls saturate a 2-bit counter at 3; one flush counts 1.
        drive(1, 4'h1, 64'h1, 5'd1, 1, 0);
        repeat (5) step("st_stall");
        drive(0, 0, 0, 0, 0, 1);
        step("st_flush");
        chk("st_stall_sat", 64'(bus.stall_cnt), 64'd3);
        chk("st_flush_one", 64'(bus.flush_cnt), 64'd1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7),
                  4'($urandom),
                  {32'($urandom), 32'($urandom)},
                  5'($urandom),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 19) == 0));
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the MIPS pipeline; generalises the fixed EX/MEM latch to any stage boundary (ID/EX, EX/MEM, MEM/WB).
Carries a control bundle, a data bundle and a destination-register index through DEPTH back-to-back register stages, each with a valid bit.
Adds hazard-unit hooks the fixed latches lack: stall (hold), flush (bubble insertion), forced-NOP control on invalid slots, and an occupancy count.

Parameters:
DATA_W, 64, data bundle width (e.g. ALU result plus store data)
CTRL_W, 4, control bundle width (e.g. WB[1:0], MEM[1:0])
RD_W, 5, destination register index width
DEPTH, 1, number of chained stages, legal 1..4
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
stall  in  1  hold all stages; input is not accepted
flush  in  1  invalidate all stages at the next edge
in_valid  in  1  input slot carries a real instruction
in_ctrl  in  CTRL_W  control bundle in
in_data  in  DATA_W  data bundle in
in_rd  in  RD_W  destination register in
out_valid  out  1  last stage valid
out_ctrl  out  CTRL_W  last stage control; all-zero when out_valid=0
out_data  out  DATA_W  last stage data
out_rd  out  RD_W  last stage rd; zero when out_valid=0
occupancy  out  $clog2(DEPTH+1)  count of valid stages

Behaviour:
- Reset (rst=0, asynchronous): all stage valid, ctrl, data and rd registers clear to 0. out_* are 0 and occupancy is 0 while rst is low. Reset mid-operation discards everything.
- Latency is DEPTH cycles from input to out_* when there are no stalls.
- Normal edge (stall=0, flush=0): stage0 <= {in_valid, in_ctrl, in_data, in_rd}; stage[i] <= stage[i-1].
- Entering an invalid slot: when in_valid=0, stage0 ctrl and rd load 0, forming a NOP bubble. Data still loads, so data is don't-care when invalid.
- stall=1, flush=0: every stage holds its value. The input is dropped; the upstream stage must hold it.
- flush=1: every stage valid, ctrl and rd clear to 0; data is retained. Flush overrides stall when both are asserted.
- Outputs are driven directly from last-stage registers; there is no combinational path from in_* to out_*.
- occupancy is a registered count of valid stages, updated in the same edge as the stages: 0 after flush; unchanged on stall; otherwise previous + in_valid − outgoing last-stage valid.
- DEPTH=1 behaves exactly as a single latch with stall and flush.
- Parameter check: DEPTH outside 1..4 raises an elaboration error.

Optional Feature:
PIPE_STAGE_REG_STATS_EN
- Defined: adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - Both clear to 0 on reset.
  - stall_cnt increments on each edge with stall=1 and flush=0.
  - flush_cnt increments on each edge with flush=1.
  - Both saturate at all-ones; no wrap.
- Undefined: neither port nor the counter logic exists, and the block matches the base behaviour exactly.

Decomposition:
- Shared package pipe_pkg: width constants (REG_IDX_W=5, WB_CTRL_W=2, MEM_CTRL_W=2), NOP_CTRL all-zero constant, and a stage payload struct typedef {valid, ctrl, data, rd} used by every boundary.
- Sub-module pipe_slot: one stage register with hold/clear/load priority (clear > hold > load). It is instantiated DEPTH times in a generate loop.
- Occupancy logic and the optional counters stay in the top module.

Test Plan:
- Reset: DEPTH=2, hold rst=0 mid-stream with valid data inside -> out_valid=0, out_ctrl=0, out_rd=0, occupancy=0 immediately, before any clock edge.
- Latency: DEPTH=2, in_valid=1, in_ctrl=4'b1010, in_data=64'h1234, in_rd=5'd9 for one cycle -> same values appear on out_* exactly 2 edges later; occupancy goes 1, 2, 1.
- Stall: load rd=5'd7 then stall=1 for 3 cycles while in_* changes to rd=5'd3 -> stage contents frozen; rd=7 emerges after the stall, rd=3 is never captured.
- Flush vs stall: pipe full (occupancy=2), assert stall=1 and flush=1 together -> next edge out_valid=0, out_ctrl=0, out_rd=0, occupancy=0, out_data unchanged.
- Bubble: in_valid=0 with in_ctrl=4'b1111, in_rd=5'd31 -> output slot shows ctrl=0, rd=0, out_valid=0; occupancy not incremented.
- Stats (with PIPE_STAGE_REG_STATS_EN, CNT_W=2): 5 stall cycles and 1 flush -> stall_cnt=3 (saturated), flush_cnt=1.
